// File: rtl/fifo_frame_reader_if.sv
// ============================================================================
//  Module      : fifo_frame_reader_if
//  Description : Bundle between fifo_frame_reader and its FIFO/consumer.
//                master = the frame reader, slave = the FIFO + consumer side.
//  Signals     : fifo_window/fifo_level (FIFO peek), fifo_r_en/fifo_r_count
//                (pop), frame_valid/frame_ready/frame_len/frame_payload
//                (payload handshake), err_pulse, drop_count (status).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_frame_reader_if #(
   parameter int OUTCUT      = 8,
   parameter int MAX_PAYLOAD = 5
);
   logic [OUTCUT*8-1:0]      fifo_window;
   logic [5:0]               fifo_level;
   logic                     fifo_r_en;
   logic [5:0]               fifo_r_count;
   logic                     frame_valid;
   logic                     frame_ready;
   logic [5:0]               frame_len;
   logic [MAX_PAYLOAD*8-1:0] frame_payload;
   logic                     err_pulse;
   logic [7:0]               drop_count;

   modport master (
      input  fifo_window, fifo_level, frame_ready,
      output fifo_r_en, fifo_r_count, frame_valid, frame_len,
             frame_payload, err_pulse, drop_count
   );

   modport slave (
      output fifo_window, fifo_level, frame_ready,
      input  fifo_r_en, fifo_r_count, frame_valid, frame_len,
             frame_payload, err_pulse, drop_count
   );
endinterface

`default_nettype wire

// File: rtl/fifo_frame_reader.sv
// ============================================================================
//  Module      : fifo_frame_reader
//  Description : Read-side frame extractor for the multi-output byte FIFO.
//                Hunts for HEADER, validates LEN, waits for the whole frame
//                to be buffered, presents the payload on valid/ready and pops
//                the frame with one multi-byte read.
//  Ports       : clk, resetn (sync, active-low), enable (low = freeze),
//                bus (fifo_frame_reader_if.master): FIFO window/level in,
//                pop strobe/count out, payload handshake, err_pulse,
//                saturating drop_count.
//  Option      : FRAME_CHECKSUM_EN - adds a trailing XOR checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_frame_reader #(
   parameter int         OUTCUT      = 8,
   parameter int         MAX_PAYLOAD = 5,
   parameter logic [7:0] HEADER      = 8'hA5
) (
   input  wire logic             clk,
   input  wire logic             resetn,
   input  wire logic             enable,
   fifo_frame_reader_if.master   bus
);

`ifdef FRAME_CHECKSUM_EN
   localparam logic [6:0] C_OVERHEAD = 7'd3;
`else
   localparam logic [6:0] C_OVERHEAD = 7'd2;
`endif

   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_LEN     = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_SETTLE  = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [5:0]               len_q, len_d;
   logic                     frame_valid_q, frame_valid_d;
   logic [5:0]               frame_len_q, frame_len_d;
   logic [MAX_PAYLOAD*8-1:0] payload_q, payload_d;
   logic                     r_en_q, r_en_d;
   logic [5:0]               r_count_q, r_count_d;
   logic                     err_q, err_d;
   logic [7:0]               drop_q, drop_d;

   logic [7:0]               win_b [OUTCUT];
   logic [6:0]               level7;
   logic [6:0]               frame_n;
   logic                     len_bad;
   logic [7:0]               drop_inc;
   logic [MAX_PAYLOAD*8-1:0] payload_next;
   logic                     chk_bad;
   logic                     unused_window;

   // Window bytes beyond the largest frame are never inspected.
   assign unused_window = ^bus.fifo_window;

   always_comb begin
      for (int k = 0; k < OUTCUT; k++) begin
         win_b[k] = bus.fifo_window[k*8 +: 8];
      end
   end

   assign level7   = {1'b0, bus.fifo_level};
   assign frame_n  = {1'b0, len_q} + C_OVERHEAD;
   assign len_bad  = (win_b[1] == 8'd0) || (win_b[1] > 8'(MAX_PAYLOAD));
   assign drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

   // Payload bytes sit at window offset 2; bytes past LEN are zero-filled.
   always_comb begin
      payload_next = '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
         if (6'(i) < len_q) begin
            payload_next[i*8 +: 8] = win_b[i+2];
         end
      end
   end

`ifdef FRAME_CHECKSUM_EN
   logic [7:0] chk_calc;
   logic [7:0] chk_rx;

   // The checksum byte position moves with LEN, so select it by search.
   always_comb begin
      chk_calc = 8'd0;
      chk_rx   = 8'd0;
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
         if (6'(i) < len_q) begin
            chk_calc = chk_calc ^ win_b[i+2];
         end
      end
      for (int j = 0; j < OUTCUT; j++) begin
         if (7'(j) == ({1'b0, len_q} + 7'd2)) begin
            chk_rx = win_b[j];
         end
      end
   end

   assign chk_bad = (chk_calc != chk_rx);
`else
   assign chk_bad = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      frame_valid_d = frame_valid_q;
      frame_len_d   = frame_len_q;
      payload_d     = payload_q;
      r_en_d        = 1'b0;
      r_count_d     = r_count_q;
      err_d         = 1'b0;
      drop_d        = drop_q;

      if (enable) begin
         unique case (state_q)
            S_HUNT: begin
               if (level7 >= 7'd1) begin
                  if (win_b[0] == HEADER) begin
                     state_d = S_LEN;
                  end else begin
                     r_en_d    = 1'b1;
                     r_count_d = 6'd1;
                     drop_d    = drop_inc;
                     state_d   = S_SETTLE;
                  end
               end
            end
            S_LEN: begin
               if (level7 >= 7'd2) begin
                  if (len_bad) begin
                     // Drop only the header so a HEADER byte inside the
                     // bad frame gets its own chance to start a frame.
                     r_en_d    = 1'b1;
                     r_count_d = 6'd1;
                     err_d     = 1'b1;
                     drop_d    = drop_inc;
                     state_d   = S_SETTLE;
                  end else begin
                     len_d   = win_b[1][5:0];
                     state_d = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (level7 >= frame_n) begin
                  if (chk_bad) begin
                     r_en_d    = 1'b1;
                     r_count_d = 6'd1;
                     err_d     = 1'b1;
                     drop_d    = drop_inc;
                     state_d   = S_SETTLE;
                  end else begin
                     frame_valid_d = 1'b1;
                     frame_len_d   = len_q;
                     payload_d     = payload_next;
                     state_d       = S_PRESENT;
                  end
               end
            end
            S_PRESENT: begin
               if (frame_valid_q && bus.frame_ready) begin
                  frame_valid_d = 1'b0;
                  r_en_d        = 1'b1;
                  r_count_d     = frame_n[5:0];
                  state_d       = S_SETTLE;
               end
            end
            S_SETTLE: begin
               // Lets the pop land before the window is looked at again.
               state_d = S_HUNT;
            end
            default: begin
               state_d = S_HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= S_HUNT;
         len_q         <= 6'd0;
         frame_valid_q <= 1'b0;
         frame_len_q   <= 6'd0;
         payload_q     <= '0;
         r_en_q        <= 1'b0;
         r_count_q     <= 6'd0;
         err_q         <= 1'b0;
         drop_q        <= 8'd0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         frame_valid_q <= frame_valid_d;
         frame_len_q   <= frame_len_d;
         payload_q     <= payload_d;
         r_en_q        <= r_en_d;
         r_count_q     <= r_count_d;
         err_q         <= err_d;
         drop_q        <= drop_d;
      end
   end

   assign bus.fifo_r_en     = r_en_q;
   assign bus.fifo_r_count  = r_count_q;
   assign bus.frame_valid   = frame_valid_q;
   assign bus.frame_len     = frame_len_q;
   assign bus.frame_payload = payload_q;
   assign bus.err_pulse     = err_q;
   assign bus.drop_count    = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
// ============================================================================
//  Module      : tb_fifo_frame_reader
//  Description : Scoreboard bench for fifo_frame_reader with a byte-queue
//                FIFO model, directed frames and hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_frame_reader;

   localparam int OUTCUT = 8;
   localparam int MAXP   = 5;
`ifdef FRAME_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   typedef struct {
      logic [5:0]        len;
      logic [MAXP*8-1:0] pay;
   } frame_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic enable = 1'b1;

   always #5 clk = ~clk;

   fifo_frame_reader_if #(.OUTCUT(OUTCUT), .MAX_PAYLOAD(MAXP)) bus ();

   fifo_frame_reader #(.OUTCUT(OUTCUT), .MAX_PAYLOAD(MAXP), .HEADER(8'hA5)) dut (
      .clk    (clk),
      .resetn (resetn),
      .enable (enable),
      .bus    (bus)
   );

   logic [7:0] fifo_q [$];
   logic [7:0] pend_q [$];
   frame_t     exp_frames [$];
   int         exp_pops [$];

   int n_cmp    = 0;
   int n_bad    = 0;
   int err_seen = 0;
   int exp_err  = 0;
   int exp_drop = 0;
   logic prev_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // FIFO model: pops on the strobe, then absorbs newly pushed bytes.
   initial begin
      bus.fifo_window = '0;
      bus.fifo_level  = '0;
      bus.frame_ready = 1'b1;
   end

   always @(negedge clk) begin
      logic [OUTCUT*8-1:0] w;
      if (!resetn) begin
         fifo_q.delete();
         pend_q.delete();
      end else begin
         if (bus.fifo_r_en) begin
            for (int i = 0; i < int'(bus.fifo_r_count); i++) begin
               if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
         end
         while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      end
      w = '0;
      for (int k = 0; k < OUTCUT; k++) begin
         if (k < fifo_q.size()) w[k*8 +: 8] = fifo_q[k];
      end
      bus.fifo_window = w;
      bus.fifo_level  = 6'(fifo_q.size());
   end

   // Monitor: checks every pop and every newly presented frame.
   always @(negedge clk) begin
      frame_t f;
      if (!resetn) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.err_pulse) err_seen++;
         if (bus.fifo_r_en) begin
            if (exp_pops.size() == 0) check("unexpected_pop", 64'd1, 64'd0);
            else check("pop_count", 64'(bus.fifo_r_count), 64'(exp_pops.pop_front()));
         end
         if (bus.frame_valid && !prev_valid) begin
            if (exp_frames.size() == 0) begin
               check("unexpected_frame", 64'd1, 64'd0);
            end else begin
               f = exp_frames.pop_front();
               check("frame_len", 64'(bus.frame_len), 64'(f.len));
               check("frame_payload", 64'(bus.frame_payload), 64'(f.pay));
            end
         end
         prev_valid = bus.frame_valid;
      end
   end

   task automatic send_good(input logic [5:0] len, input logic [MAXP*8-1:0] pay);
      logic [7:0] chk;
      chk = 8'd0;
      exp_frames.push_back('{len: len, pay: pay});
      exp_pops.push_back(int'(len) + 2 + CHK);
      pend_q.push_back(8'hA5);
      pend_q.push_back({2'b00, len});
      for (int i = 0; i < int'(len); i++) begin
         pend_q.push_back(pay[i*8 +: 8]);
         chk = chk ^ pay[i*8 +: 8];
      end
      if (CHK != 0) pend_q.push_back(chk);
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while (!(exp_frames.size() == 0 && exp_pops.size() == 0 &&
               fifo_q.size() == 0 && pend_q.size() == 0) && c < 300) begin
         @(negedge clk);
         c++;
      end
      if (c >= 300) check({name, "_timeout"}, 64'd1, 64'd0);
      repeat (3) @(negedge clk);
      check({name, "_err_count"}, 64'(err_seen), 64'(exp_err));
      check({name, "_drop_count"}, 64'(bus.drop_count), 64'(exp_drop));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;

      // 1: reset
      resetn = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("reset_r_en", 64'(bus.fifo_r_en), 64'd0);
      end
      check("reset_valid", 64'(bus.frame_valid), 64'd0);
      check("reset_len", 64'(bus.frame_len), 64'd0);
      check("reset_payload", 64'(bus.frame_payload), 64'd0);
      check("reset_r_count", 64'(bus.fifo_r_count), 64'd0);
      check("reset_err", 64'(bus.err_pulse), 64'd0);
      check("reset_drop", 64'(bus.drop_count), 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // 2: good frame A5 03 11 22 33
      send_good(6'd3, 40'h00_0033_2211);
      wait_idle("good_frame");

      // 3: garbage then frame
      exp_pops.push_back(1);
      exp_pops.push_back(1);
      exp_drop += 2;
      pend_q.push_back(8'h00);
      pend_q.push_back(8'hFF);
      send_good(6'd1, 40'h7E);
      wait_idle("garbage");

      // 4: bad length; the 09 byte is then dropped in hunt
      exp_pops.push_back(1);
      exp_pops.push_back(1);
      exp_err++;
      exp_drop += 2;
      pend_q.push_back(8'hA5);
      pend_q.push_back(8'h09);
      send_good(6'd2, 40'hCCBB);
      wait_idle("bad_len");

      // 5: backpressure
      bus.frame_ready = 1'b0;
      send_good(6'd2, 40'h5544);
      c = 0;
      while (!bus.frame_valid && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("bp_valid_seen", 64'(bus.frame_valid), 64'd1);
      repeat (10) begin
         @(negedge clk);
         check("bp_hold", {23'd0, bus.frame_valid, bus.fifo_r_en, bus.frame_payload},
               {23'd0, 1'b1, 1'b0, 40'h5544});
      end
      bus.frame_ready = 1'b1;
      @(negedge clk);
      check("bp_pop_after_ready", 64'(bus.fifo_r_en), 64'd1);
      wait_idle("backpressure");

      // 6: enable low while in WAIT with the remaining bytes arriving
      exp_frames.push_back('{len: 6'd3, pay: 40'h03_0201});
      exp_pops.push_back(5 + CHK);
      pend_q.push_back(8'hA5);
      pend_q.push_back(8'h03);
      pend_q.push_back(8'h01);
      repeat (6) @(negedge clk);
      enable = 1'b0;
      pend_q.push_back(8'h02);
      pend_q.push_back(8'h03);
      if (CHK != 0) pend_q.push_back(8'h00);
      repeat (8) begin
         @(negedge clk);
         check("disabled_idle", {62'd0, bus.frame_valid, bus.fifo_r_en}, 64'd0);
      end
      enable = 1'b1;
      wait_idle("enable");

`ifdef FRAME_CHECKSUM_EN
      // bad checksum: every byte ends up dropped one at a time
      for (int i = 0; i < 5; i++) exp_pops.push_back(1);
      exp_err++;
      exp_drop += 5;
      pend_q.push_back(8'hA5);
      pend_q.push_back(8'h02);
      pend_q.push_back(8'h01);
      pend_q.push_back(8'h02);
      pend_q.push_back(8'h00);
      wait_idle("bad_chk");
`endif

      // 7: reset in the middle of a frame
      pend_q.push_back(8'hA5);
      pend_q.push_back(8'h04);
      pend_q.push_back(8'h01);
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("midreset_valid", 64'(bus.frame_valid), 64'd0);
      check("midreset_drop", 64'(bus.drop_count), 64'd0);
      check("midreset_r_en", 64'(bus.fifo_r_en), 64'd0);
      resetn = 1'b1;
      exp_drop = 0;
      send_good(6'd5, 40'h55_4433_2211);
      wait_idle("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
